// File: rtl/coproc_cmd_if.sv
// CPU-side command initiator for the image coprocessor: queues bus-written
// commands, launches them one at a time, and tracks completion/timeout/overflow.
module coproc_cmd_if #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 24'hFFFFFF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        start,
    output logic [2:0]  func,
    output logic        gray,
    output logic        img_idx,
    input  logic        rdy,
    input  logic        done,
    output logic        irq
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = AW + 1;
    localparam int unsigned TMO_W = 24;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY} state_t;

    typedef struct packed {
        logic       img_idx;
        logic       gray;
        logic [2:0] func;
    } cmd_t;

    state_t             state_q, state_d;
    cmd_t               mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_stk, err_stk, ovf_stk, irq_en;
    logic               done_d, err_d, ovf_d, irq_en_d;
    logic               full, empty, cmd_wr, clr_wr, push, pop;
    logic               done_set, err_set, ovf_set;
    logic [31:0]        status_w, rd_mux;
    cmd_t               wr_cmd;

    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:17], wdata[15:10], wdata[7:5]};

    assign full   = (occ_q == OCC_W'(FIFO_DEPTH));
    assign empty  = (occ_q == '0);
    assign cmd_wr = we && (addr == 2'd0);
    assign clr_wr = we && (addr == 2'd2);
    assign wr_cmd = cmd_t'(wdata[4:0]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, queue control, sticky/status next values
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        pop      = 1'b0;
        done_set = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && rdy) begin
                    pop     = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tmo_d   = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (done) begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A full queue still accepts a write when the head leaves this cycle
        push    = cmd_wr && (!full || pop);
        ovf_set = cmd_wr && !push;

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // Set events take priority over a coincident clear
        done_d   = done_set | (done_stk & ~(clr_wr & wdata[0]));
        err_d    = err_set  | (err_stk  & ~(clr_wr & wdata[1]));
        ovf_d    = ovf_set  | (ovf_stk  & ~(clr_wr & wdata[2]));
        irq_en_d = (clr_wr && wdata[8]) ? wdata[9] : irq_en;
        count_d  = ((clr_wr && wdata[16]) ? '0 : count_q) + CNT_W'(done_set);

        status_w      = '0;
        status_w[0]   = (state_q != S_IDLE);
        status_w[1]   = done_stk;
        status_w[2]   = err_stk;
        status_w[3]   = ovf_stk;
        status_w[4]   = irq_en;
        status_w[7:5] = 3'(occ_q);
        status_w[8]   = full;
        status_w[9]   = empty;

        case (addr)
            2'd1:    rd_mux = status_w;
            2'd3:    rd_mux = 32'(count_q);
            default: rd_mux = '0;
        endcase
    end

    // Queue storage (no reset needed; validity tracked by occupancy)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_cmd;
    end

    // Pointers, counters, status and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ_q    <= '0;
            tmo_q    <= '0;
            count_q  <= '0;
            done_stk <= 1'b0;
            err_stk  <= 1'b0;
            ovf_stk  <= 1'b0;
            irq_en   <= 1'b0;
            rdata    <= '0;
            start    <= 1'b0;
            func     <= '0;
            gray     <= 1'b0;
            img_idx  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                func    <= mem[rd_ptr].func;
                gray    <= mem[rd_ptr].gray;
                img_idx <= mem[rd_ptr].img_idx;
            end
            occ_q    <= occ_d;
            tmo_q    <= tmo_d;
            count_q  <= count_d;
            done_stk <= done_d;
            err_stk  <= err_d;
            ovf_stk  <= ovf_d;
            irq_en   <= irq_en_d;
            if (re) rdata <= rd_mux;
            start    <= (state_q == S_LAUNCH);
            irq      <= irq_en_d & (done_d | err_d | ovf_d);
        end
    end

endmodule

// File: tb/tb_coproc_cmd_if.sv
// Scoreboard bench for coproc_cmd_if: expected commands are queued on write and
// compared at each start pulse; a small coprocessor model returns done.
module tb_coproc_cmd_if;

    logic        clk, rst_n;
    logic [1:0]  addr;
    logic        we, re;
    logic [31:0] wdata, rdata;
    logic        start, gray, img_idx, rdy, done, irq;
    logic [2:0]  func;
    logic        done_auto, force_done, auto_done;
    int          done_delay, dly, starts, ntot, nbad;
    logic [4:0]  exp_q [$];

    assign done = done_auto | force_done;

    coproc_cmd_if #(.FIFO_DEPTH(4), .TIMEOUT_CYC(100), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .re(re),
        .wdata(wdata), .rdata(rdata), .start(start), .func(func),
        .gray(gray), .img_idx(img_idx), .rdy(rdy), .done(done), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Coprocessor model: done pulse done_delay cycles after each start
    initial begin
        done_auto = 1'b0;
        dly = 0;
        forever begin
            @(negedge clk);
            done_auto = 1'b0;
            if (!rst_n) dly = 0;
            else if (start && auto_done) dly = done_delay;
            else if (dly > 0) begin
                dly--;
                if (dly == 0) done_auto = 1'b1;
            end
        end
    end

    // Start monitor: pop the scoreboard and compare the launched command
    initial begin
        logic [4:0] e;
        starts = 0;
        forever begin
            @(negedge clk);
            if (start) begin
                starts++;
                if (exp_q.size() == 0) chk("unexp_start", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("start_cmd", 32'({img_idx, gray, func}), 32'(e));
                end
            end
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        d = rdata;
    endtask

    task automatic wait_start(input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= budget && !seen; i++) begin
            @(negedge clk);
            if (start) begin
                seen = 1'b1;
                n = i;
            end
        end
        if (!seen) chk("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_count(input int target, input int budget);
        int i;
        i = 0;
        while (starts < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (starts < target) chk("count_timeout", 32'(starts), 32'(target));
    endtask

    initial begin
        logic [31:0] d;
        int n, sbase;
        ntot = 0; nbad = 0;
        rst_n = 1'b0; addr = '0; we = 1'b0; re = 1'b0; wdata = '0; rdy = 1'b0;
        auto_done = 1'b0; force_done = 1'b0; done_delay = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({start, func, gray, img_idx, irq}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        bus_rd(2'd1, d); chk("rst_status", d, 32'h200);
        bus_rd(2'd3, d); chk("rst_count", d, 32'd0);

        // Single op with latency and irq
        bus_wr(2'd2, 32'h300);
        rdy = 1'b1; auto_done = 1'b1; done_delay = 50;
        exp_q.push_back(5'h13);
        bus_wr(2'd0, 32'h13);
        @(negedge clk); chk("lat_pop", 32'(start), 32'd0);
        @(negedge clk); chk("lat_start", 32'(start), 32'd1);
        @(negedge clk); chk("start_1cyc", 32'(start), 32'd0);
        repeat (60) @(negedge clk);
        bus_rd(2'd1, d); chk("single_status", d, 32'h212);
        bus_rd(2'd3, d); chk("single_count", d, 32'd1);
        chk("single_irq", 32'(irq), 32'd1);
        bus_wr(2'd2, 32'h1);
        chk("irq_clr", 32'(irq), 32'd0);

        // Queue order and overflow
        bus_wr(2'd2, 32'h10007);
        rdy = 1'b0; done_delay = 20;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(5'(i));
            bus_wr(2'd0, 32'(i));
        end
        bus_wr(2'd0, 32'h5);
        bus_rd(2'd1, d); chk("full_ovf_status", d, 32'h198);
        rdy = 1'b1;
        wait_count(5, 400);
        repeat (30) @(negedge clk);
        chk("queue_starts", 32'(starts), 32'd5);
        bus_rd(2'd3, d); chk("queue_count", d, 32'd4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // rdy gating
        bus_wr(2'd2, 32'h7);
        rdy = 1'b0;
        exp_q.push_back(5'h0D);
        bus_wr(2'd0, 32'h0D);
        repeat (5) @(negedge clk);
        chk("gate_nostart", 32'(starts), 32'd5);
        bus_rd(2'd1, d); chk("gate_status", d, 32'h30);
        rdy = 1'b1;
        @(negedge clk); chk("gate_pop", 32'(start), 32'd0);
        @(negedge clk); chk("gate_start", 32'(start), 32'd1);
        repeat (30) @(negedge clk);

        // Timeout, then the next queued command launches
        auto_done = 1'b0;
        bus_wr(2'd2, 32'h10007);
        rdy = 1'b0;
        exp_q.push_back(5'h06); bus_wr(2'd0, 32'h06);
        exp_q.push_back(5'h11); bus_wr(2'd0, 32'h11);
        rdy = 1'b1;
        wait_start(10, n);
        wait_start(200, n);
        chk("tmo_gap", 32'(n), 32'd102);
        repeat (110) @(negedge clk);
        bus_rd(2'd1, d); chk("tmo_status", d, 32'h214);
        bus_rd(2'd3, d); chk("tmo_count", d, 32'd0);

        // Coincident clear and done: set wins
        bus_wr(2'd2, 32'h7);
        exp_q.push_back(5'h07);
        bus_wr(2'd0, 32'h07);
        wait_start(10, n);
        @(negedge clk);
        addr = 2'd2; wdata = 32'h1; we = 1'b1; force_done = 1'b1;
        @(negedge clk);
        we = 1'b0; force_done = 1'b0;
        bus_rd(2'd1, d); chk("coinc_status", d, 32'h212);
        bus_rd(2'd3, d); chk("coinc_count", d, 32'd1);

        // Write to a full queue in the same cycle as a pop is accepted
        rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(5'(i));
            bus_wr(2'd0, 32'(i));
        end
        bus_rd(2'd1, d); chk("full2_status", d, 32'h192);
        sbase = starts;
        auto_done = 1'b1; done_delay = 5;
        @(negedge clk);
        rdy = 1'b1; addr = 2'd0; wdata = 32'h5; we = 1'b1;
        exp_q.push_back(5'h05);
        @(negedge clk);
        we = 1'b0;
        bus_rd(2'd1, d); chk("fullpop_noovf", d & 32'h8, 32'd0);
        wait_count(sbase + 5, 300);
        repeat (10) @(negedge clk);
        chk("fullpop_drained", 32'(exp_q.size()), 32'd0);
        bus_rd(2'd3, d); chk("fullpop_count", d, 32'd6);

        // Async reset while busy with two commands queued
        auto_done = 1'b0;
        exp_q.push_back(5'h1F);
        bus_wr(2'd0, 32'h1F);
        wait_start(10, n);
        bus_wr(2'd0, 32'h02);
        bus_wr(2'd0, 32'h03);
        bus_rd(2'd3, d);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs", 32'({start, func, gray, img_idx, irq}), 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        sbase = starts;
        repeat (20) @(negedge clk);
        chk("arst_nostart", 32'(starts), 32'(sbase));
        bus_rd(2'd1, d); chk("arst_status", d, 32'h200);

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
